dsc_mul_seq: RTL
================

# dsc_mul_seq

Sequencer for the serial deterministic stochastic multiplier datapath (two SNGs, AND multiplier, stoch2bin counter). It accepts operand pairs over a valid/ready handshake and registers them onto the datapath. It then issues a one-cycle clear, holds the datapath enable for exactly the full 2^(NUM_INPUTS*SNG_WIDTH)-cycle stream (or until early shutoff), and captures the binary result into an output register held under a valid/ready handshake. It sits between the host/bus logic and the datapath instance, which it owns exclusively.

## Interface
- SNG_WIDTH, 10, operand width W; also the width of each SNG counter
- NUM_INPUTS, 2, number of operands; result width R = NUM_INPUTS*SNG_WIDTH, stream length N = 2^R
- EARLY_STOP, 0, 1 = end RUN when datapath `mul_ov` asserts; 0 = ignore `mul_ov`

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  sequencer can accept (high only in IDLE)
- in_a  in  W  operand A (binary)
- in_b  in  W  operand B (binary)
- abort  in  1  synchronous cancel of the operation in flight
- out_valid  out  1  result held in out_z
- out_ready  in  1  consumer takes result
- out_z  out  R  captured product count
- busy  out  1  high in every state except IDLE
- mul_clr  out  1  one-cycle active-high clear to datapath SNGs and counter
- mul_en  out  1  datapath enable
- mul_a  out  W  registered operand A to datapath
- mul_b  out  W  registered operand B to datapath
- mul_z  in  R  datapath stoch2bin counter value
- mul_ov  in  1  datapath early-shutoff/overflow indicator

## Operation
- States: IDLE, CLEAR, RUN, CAPTURE, DONE. All outputs are decoded from the state or registered.
- IDLE: in_ready=1. On in_valid, latch in_a/in_b into mul_a/mul_b.
  - If either operand is 0, go to DONE with out_z loaded to 0 (zero shortcut; datapath never runs).
  - Otherwise go to CLEAR.
- CLEAR: mul_clr=1 for exactly one cycle, mul_en=0, cycle counter cleared to 0. Go to RUN.
- RUN: mul_en=1; R-bit cycle counter increments every cycle.
  - Exit to CAPTURE at the edge where counter==N-1, so mul_en is high for exactly N cycles.
  - With EARLY_STOP=1, also exit on the first edge where mul_ov=1; that cycle counts as enabled.
- CAPTURE: mul_en=0 for one cycle so the datapath counter settles. out_z <= mul_z at the exit edge. Go to DONE.
- DONE: out_valid=1 and out_z stable. On out_ready, go to IDLE; the next operand pair cannot be accepted in that same cycle.
- abort: in CLEAR, RUN or CAPTURE, return to IDLE at the next edge.
  - mul_en drops, out_z is unchanged, and no out_valid is produced.
  - abort is ignored in IDLE and DONE.
- Cycle counter is R+1 bits internally, so N is representable; it never wraps during RUN.
- mul_a/mul_b change only on an IDLE accept, so they are stable for the whole operation.

## Timing
- Reset (rst low, asynchronous): state=IDLE. out_z=0, mul_a=0, mul_b=0, counter=0. out_valid=0, mul_en=0, mul_clr=0, busy=0. in_ready=1 once reset is released.
- Reset mid-RUN: mul_en falls immediately (asynchronously); no result is produced.
- Nonzero operands, no early stop: accept edge E. CLEAR during cycle E..E+1. mul_en high for cycles E+1..E+N+1. CAPTURE follows. out_valid rises after edge E+N+2.
- Zero shortcut: out_valid rises after the accept edge itself (latency 1).
- Early stop at RUN cycle k (0-based): mul_en high for k+1 cycles; out_valid rises after edge E+k+3.
- abort and mul_ov asserted in the same RUN cycle: abort wins.
- Counter at N-1 and mul_ov asserted in the same cycle: single exit to CAPTURE.
- out_valid holds with out_z constant until out_ready (back-pressure unlimited).

## Test plan
- Use SNG_WIDTH=4, EARLY_STOP=0 (N=256) with a behavioural datapath model. Apply a=5, b=9 -> mul_clr pulses 1 cycle, mul_en high exactly 256 cycles, out_valid after edge E+258, out_z = model count.
- Apply a=0, b=7 -> out_valid at E+1, out_z=0, mul_en never high, mul_clr never high.
- Apply a=15, b=15, then hold out_ready=0 for 20 cycles -> out_z stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge, new pair accepted the cycle after.
- Assert abort at RUN cycle 100 -> mul_en low next cycle, out_valid never asserts, out_z retains previous result, in_ready=1.
- EARLY_STOP=1, drive mul_ov=1 at RUN cycle 40 -> exactly 41 enabled cycles, out_valid after edge E+43.
- Drive rst low at RUN cycle 10 -> mul_en low immediately, all outputs at reset values; after release, a=3, b=2 completes normally.

Source files
------------

// File: rtl/dsc_mul_seq_if.sv
// Operand/result handshake bundle between host logic and the multiplier sequencer.
// master = host side, slave = sequencer side.
interface dsc_mul_seq_if #(
  parameter int W = 10,
  parameter int R = 20
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [R-1:0] out_z;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_z
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_z
  );
endinterface

// File: rtl/dsc_mul_seq.sv
// Sequencer for the serial deterministic stochastic multiplier datapath:
// accepts an operand pair, clears and runs the datapath for a full stream, captures the count.
//
// state   | meaning
// IDLE    | waiting for an operand pair, in_ready high
// CLEAR   | one-cycle clear pulse to SNGs and stoch2bin counter
// RUN     | datapath enabled, cycle counter advancing
// CAPTURE | enable dropped for one cycle so the datapath count settles
// DONE    | result held on out_z with out_valid until out_ready
module dsc_mul_seq #(
  parameter int SNG_WIDTH  = 10,
  parameter int NUM_INPUTS = 2,
  parameter int EARLY_STOP = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  dsc_mul_seq_if.slave                    hs,
  input  logic                            abort,
  output logic                            busy,
  output logic                            mul_clr,
  output logic                            mul_en,
  output logic [SNG_WIDTH-1:0]            mul_a,
  output logic [SNG_WIDTH-1:0]            mul_b,
  input  logic [NUM_INPUTS*SNG_WIDTH-1:0] mul_z,
  input  logic                            mul_ov
);

  localparam int R = NUM_INPUTS * SNG_WIDTH;
  // One extra bit so the stream length itself is representable.
  localparam logic [R:0] CNT_LAST = {1'b0, {R{1'b1}}};
  localparam logic [R:0] CNT_ONE  = {{R{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, DONE} state_t;

  state_t     state;
  logic [R:0] cnt;
  logic       run_last;
  logic       abortable;

  assign run_last  = (cnt == CNT_LAST) || ((EARLY_STOP != 0) && mul_ov);
  assign abortable = (state == CLEAR) || (state == RUN) || (state == CAPTURE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_clr      <= 1'b0;
      mul_en       <= 1'b0;
      busy         <= 1'b0;
      hs.in_ready  <= 1'b1;
      hs.out_valid <= 1'b0;
      hs.out_z     <= '0;
    end else if (abort && abortable) begin
      // Abort drops everything without touching the previous result.
      state       <= IDLE;
      mul_clr     <= 1'b0;
      mul_en      <= 1'b0;
      busy        <= 1'b0;
      hs.in_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (hs.in_valid) begin
            mul_a       <= hs.in_a;
            mul_b       <= hs.in_b;
            cnt         <= '0;
            busy        <= 1'b1;
            hs.in_ready <= 1'b0;
            if (hs.in_a == '0 || hs.in_b == '0) begin
              state        <= DONE;
              hs.out_z     <= '0;
              hs.out_valid <= 1'b1;
            end else begin
              state   <= CLEAR;
              mul_clr <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state   <= RUN;
          mul_clr <= 1'b0;
          mul_en  <= 1'b1;
        end
        RUN: begin
          cnt <= cnt + CNT_ONE;
          if (run_last) begin
            state  <= CAPTURE;
            mul_en <= 1'b0;
          end
        end
        CAPTURE: begin
          state        <= DONE;
          hs.out_z     <= mul_z;
          hs.out_valid <= 1'b1;
        end
        DONE: begin
          if (hs.out_ready) begin
            state        <= IDLE;
            hs.out_valid <= 1'b0;
            hs.in_ready  <= 1'b1;
            busy         <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          mul_clr      <= 1'b0;
          mul_en       <= 1'b0;
          busy         <= 1'b0;
          hs.in_ready  <= 1'b1;
          hs.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
